// File: rtl/aes_pkg.sv
// Shared types and constants for the sequential AES MixColumns engine.
// The INV_MIXCOL_EN build uses INV_MIX_BASE; the forward build uses only MIX_BASE.
package aes_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // First row of the circulant matrices; row r uses BASE[(c - r) mod 4].
  localparam byte_t MIX_BASE     [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
  localparam byte_t INV_MIX_BASE [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  // Multiply by x modulo the AES polynomial 0x11B.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mixcol_seq_if.sv
// Column stream interface for aes_mixcol_seq, plus an FSM state debug tap.
// The inv select exists only when INV_MIXCOL_EN is defined.
interface aes_mixcol_seq_if;
  import aes_pkg::*;

  // Both sides use valid/ready: a transfer happens on a clock edge where valid
  // and ready are both high; a source holds valid and data stable until then.
  logic        in_valid;
  logic        in_ready;
  logic [31:0] col_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] col_out;
  logic        busy;
  state_t      dbg_state;
`ifdef INV_MIXCOL_EN
  logic        inv;
`endif

`ifdef INV_MIXCOL_EN
  modport master (
    output in_valid, col_in, out_ready, inv,
    input  in_ready, out_valid, col_out, busy, dbg_state
  );
  modport slave (
    input  in_valid, col_in, out_ready, inv,
    output in_ready, out_valid, col_out, busy, dbg_state
  );
`else
  modport master (
    output in_valid, col_in, out_ready,
    input  in_ready, out_valid, col_out, busy, dbg_state
  );
  modport slave (
    input  in_valid, col_in, out_ready,
    output in_ready, out_valid, col_out, busy, dbg_state
  );
`endif

endinterface

// File: rtl/gfmult.sv
// Combinational GF(2^8) multiplier over the AES polynomial 0x11B.
module gfmult
  import aes_pkg::*;
(
  input  byte_t val_a,
  input  byte_t val_b,
  output byte_t val_p
);

  byte_t a_sh;
  byte_t prod;

  always_comb begin
    a_sh = val_a;
    prod = '0;
    for (int i = 0; i < 8; i++) begin
      if (val_b[i]) prod = prod ^ a_sh;
      a_sh = xtime(a_sh);
    end
    val_p = prod;
  end

endmodule

// File: rtl/aes_mixcol_seq.sv
// Sequential MixColumns: one column in 16 CALC cycles through a single shared gfmult.
// Define INV_MIXCOL_EN to add the inv select (InvMixColumns coefficients).
module aes_mixcol_seq
  import aes_pkg::*;
#(
  parameter int BYTE_W = 8
)(
  input logic             clk,
  input logic             rst_n,
  aes_mixcol_seq_if.slave bus
);

  localparam int COL_W = 4 * BYTE_W;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  byte_t            acc;
  byte_t            acc_nxt;
  logic [COL_W-1:0] col_q;
  logic [COL_W-1:0] col_out_q;
  byte_t            res0_q;
  byte_t            res1_q;
  byte_t            res2_q;

  logic [1:0] row;
  logic [1:0] term;
  logic [1:0] idx;
  byte_t      coef;
  byte_t      s_c;
  byte_t      product;

  assign row  = cnt[3:2];
  assign term = cnt[1:0];
  // 2-bit subtraction wraps, giving (c - r) mod 4 for the circulant lookup.
  assign idx  = term - row;

`ifdef INV_MIXCOL_EN
  logic inv_q;

  always_comb begin
    coef = inv_q ? INV_MIX_BASE[idx] : MIX_BASE[idx];
  end
`else
  always_comb begin
    coef = MIX_BASE[idx];
  end
`endif

  always_comb begin
    s_c = '0;
    case (term)
      2'd0:    s_c = col_q[31:24];
      2'd1:    s_c = col_q[23:16];
      2'd2:    s_c = col_q[15:8];
      default: s_c = col_q[7:0];
    endcase
  end

  gfmult u_gfmult (
    .val_a (coef),
    .val_b (s_c),
    .val_p (product)
  );

  assign acc_nxt = acc ^ product;

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = CALC;
      end
      CALC: begin
        bus.busy = 1'b1;
        if (cnt == 4'd15) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      col_q     <= '0;
      col_out_q <= '0;
      res0_q    <= '0;
      res1_q    <= '0;
      res2_q    <= '0;
`ifdef INV_MIXCOL_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            col_q <= bus.col_in;
            cnt   <= '0;
            acc   <= '0;
`ifdef INV_MIXCOL_EN
            inv_q <= bus.inv;
`endif
          end
        end
        CALC: begin
          cnt <= cnt + 4'd1;
          if (term == 2'd3) begin
            acc <= '0;
            // Rows 0..2 are staged so col_out only moves once the column is complete.
            case (row)
              2'd0:    res0_q <= acc_nxt;
              2'd1:    res1_q <= acc_nxt;
              2'd2:    res2_q <= acc_nxt;
              default: col_out_q <= {res0_q, res1_q, res2_q, acc_nxt};
            endcase
          end else begin
            acc <= acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.col_out   = col_out_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// Scoreboard bench for aes_mixcol_seq with directed MixColumns vectors.
// Define INV_MIXCOL_EN to also exercise the inverse path.
module tb_aes_mixcol_seq;
  import aes_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  logic [31:0] exp_q[$];

  aes_mixcol_seq_if bus ();

  aes_mixcol_seq #(.BYTE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model for the inverse test
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_mix(input logic [31:0] col, input logic inv);
    logic [7:0] s0, s1, s2, s3;
    s0 = col[31:24]; s1 = col[23:16]; s2 = col[15:8]; s3 = col[7:0];
    if (!inv)
      return {gm(s0,8'h02)^gm(s1,8'h03)^s2^s3,
              s0^gm(s1,8'h02)^gm(s2,8'h03)^s3,
              s0^s1^gm(s2,8'h02)^gm(s3,8'h03),
              gm(s0,8'h03)^s1^s2^gm(s3,8'h02)};
    return {gm(s0,8'h0e)^gm(s1,8'h0b)^gm(s2,8'h0d)^gm(s3,8'h09),
            gm(s0,8'h09)^gm(s1,8'h0e)^gm(s2,8'h0b)^gm(s3,8'h0d),
            gm(s0,8'h0d)^gm(s1,8'h09)^gm(s2,8'h0e)^gm(s3,8'h0b),
            gm(s0,8'h0b)^gm(s1,8'h0d)^gm(s2,8'h09)^gm(s3,8'h0e)};
  endfunction

  // driver: returns just after the accepting edge, expected result queued
  task automatic send(input logic [31:0] col, input logic [31:0] exp, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.col_in   = col;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("accept_timeout", 32'd1, 32'd0);
      bus.in_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    @(posedge clk);
    acc_cyc = cyc;
    exp_q.push_back(exp);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output int k);
    k = 0;
    while (!bus.out_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (k >= 60) check("out_valid_timeout", 32'd1, 32'd0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        check("col_out", bus.col_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    int a1, a2, k;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.col_in    = '0;
    bus.out_ready = 1'b1;
`ifdef INV_MIXCOL_EN
    bus.inv = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_col_out",   bus.col_out,            32'h0);
    check("rst_state",     {30'd0, bus.dbg_state}, {30'd0, IDLE});
    rst_n = 1'b1;

    // single column, latency and in_ready during CALC
    send(32'hdb135345, 32'h8e4da1bc, a1);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        k = i;
        break;
      end
      check("calc_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("calc_col_out_hold", bus.col_out, 32'h0);
    end
    check("latency", k, 17);
    @(negedge clk);
    check("post_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post_col_out_retained", bus.col_out, 32'h8e4da1bc);

    // back-to-back columns
    send(32'hd4bf5d30, 32'h046681e5, a1);
    send(32'hf20a225c, 32'h9fdc589d, a2);
    check("b2b_spacing", a2 - a1, 18);
    wait_out_valid(k);
    @(negedge clk);

    // stalled output
    bus.out_ready = 1'b0;
    send(32'h01010101, 32'h01010101, a1);
    wait_out_valid(k);
    for (int i = 0; i < 10; i++) begin
      check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_col_out",   bus.col_out, 32'h01010101);
      check("stall_in_ready",  {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(32'hc6c6c6c6, 32'hc6c6c6c6, a1);
    wait_out_valid(k);
    @(negedge clk);

    // reset while cnt=7 in CALC
    send(32'h01010101, 32'h01010101, a1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_state",     {30'd0, bus.dbg_state}, {30'd0, IDLE});
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_col_out",   bus.col_out,            32'h0);
    check("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
    send(32'h01010101, 32'h01010101, a1);
    wait_out_valid(k);
    @(negedge clk);

`ifdef INV_MIXCOL_EN
    bus.inv = 1'b1;
    send(32'h046681e5, 32'hd4bf5d30, a1);
    wait_out_valid(k);
    @(negedge clk);
    bus.inv = 1'b0;
    send(32'h8e4da1bc, ref_mix(32'h8e4da1bc, 1'b0), a1);
    repeat (5) @(negedge clk);
    bus.inv = 1'b1;
    wait_out_valid(k);
    @(negedge clk);
    bus.inv = 1'b0;
`endif

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
